// File: rtl/script_read_arbiter.sv
// script_read_arbiter
//   Shares one registered-latency script memory read port between
//   C_NUM_REQ requesters. Round-robin grant with a valid/ready handshake,
//   the memory address is held for the whole read, and each returned word
//   is steered back to the requester that issued it as a one-cycle pulse.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester read request
//   req_addr   : per-requester 16-bit word address, slice i = [16*i+15:16*i]
//   req_ready  : one-hot grant (combinational, only in the grant window)
//   rsp_valid  : one-hot, one-cycle response strobe
//   rsp_data   : response word shared by all requesters (held until next capture)
//   mem_addr   : registered address to the memory read port
//   mem_data   : read data from the memory
//   busy       : high while a read is in flight
module script_read_arbiter #(
  parameter int C_NUM_REQ     = 4,
  parameter int C_MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_NUM_REQ-1:0]      req_valid,
  input  logic [16*C_NUM_REQ-1:0]   req_addr,
  output logic [C_NUM_REQ-1:0]      req_ready,
  output logic [C_NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]               rsp_data,
  output logic [15:0]               mem_addr,
  input  logic [31:0]               mem_data,
  output logic                      busy
);

  localparam int RW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam logic [1:0] CNT_INIT = 2'(C_MEM_LATENCY - 1);
  localparam logic [RW-1:0] RR_INIT = RW'(C_NUM_REQ - 1);
  localparam logic [C_NUM_REQ-1:0] ONE = {{(C_NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [RW-1:0]          rr_q, rr_d;
  logic [RW-1:0]          owner_q, owner_d;
  logic [15:0]            mem_addr_q, mem_addr_d;
  logic [C_NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   busy_q, busy_d;

  logic [15:0]            addr_arr_s [C_NUM_REQ];
  logic [RW-1:0]          scan_idx_s;
  logic [RW-1:0]          win_idx_s;
  logic                   win_found_s;
  logic                   grant_window_s;
  logic                   accept_s;

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_REQ; gi++) begin : g_addr
      assign addr_arr_s[gi] = req_addr[16*gi +: 16];
    end
  endgenerate

  // Round-robin scan: first valid requester starting just after rr_q, with wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    for (int j = 1; j <= C_NUM_REQ; j++) begin
      scan_idx_s = RW'((int'(rr_q) + j) % C_NUM_REQ);
      if (!win_found_s && req_valid[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant window is IDLE or CAPTURE; the grant never looks at req_addr.
  always_comb begin
    grant_window_s = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);
    accept_s       = grant_window_s && win_found_s;
    if (accept_s) begin
      req_ready = ONE << win_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic: latency countdown, response capture, and accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        // Counter reaches zero on entry to CAPTURE, so CAPTURE lands exactly
        // C_MEM_LATENCY cycles after the accept.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        rsp_data_d  = mem_data;
        rsp_valid_d = ONE << owner_q;
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // An accept in CAPTURE overrides the return to IDLE (back-to-back reads).
    if (accept_s) begin
      mem_addr_d = addr_arr_s[win_idx_s];
      owner_d    = win_idx_s;
      rr_d       = win_idx_s;
      cnt_d      = CNT_INIT;
      busy_d     = 1'b1;
      if (C_MEM_LATENCY == 1) begin
        state_d = ST_CAPTURE;
      end else begin
        state_d = ST_WAIT;
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // State and output registers; reset discards any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      rr_q        <= RR_INIT;
      owner_q     <= '0;
      mem_addr_q  <= 16'h0000;
      rsp_valid_q <= '0;
      rsp_data_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_script_read_arbiter.sv
// Testbench for script_read_arbiter: two instances (latency 1 and 3) see the
// same request stimulus; each is compared every cycle against a cycle-count
// reference model (grant window timing, round-robin order, response queue).
module tb_script_read_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [16*N-1:0] req_addr = '0;

  logic [N-1:0]  rdy1, rv1, rdy3, rv3;
  logic [31:0]   rd1, rd3, md1, md3;
  logic [15:0]   ma1, ma3, p1, p2;
  logic          bsy1, bsy3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory models: latency 1 is combinational on the held address,
  // latency 3 adds two register stages.
  assign md1 = memf(ma1);
  always @(posedge clk) begin
    p1 <= ma3;
    p2 <= p1;
  end
  assign md3 = memf(p2);

  script_read_arbiter #(.C_NUM_REQ(N), .C_MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy1), .rsp_valid(rv1), .rsp_data(rd1), .mem_addr(ma1),
    .mem_data(md1), .busy(bsy1));

  script_read_arbiter #(.C_NUM_REQ(N), .C_MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy3), .rsp_valid(rv3), .rsp_data(rd3), .mem_addr(ma3),
    .mem_data(md3), .busy(bsy3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model state, per instance.
  typedef struct {
    int u;
    int cyc;
    int idx;
    logic [31:0] d;
  } rsp_t;

  rsp_t        rq[$];
  int          rr_m[2];
  int          next_win[2];
  int          busy_end[2];
  logic [15:0] eaddr[2];
  logic [31:0] edata[2];
  int          k = 0;

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      rr_m[u]     = N - 1;
      next_win[u] = 0;
      busy_end[u] = -1;
      eaddr[u]    = 16'h0000;
      edata[u]    = 32'h0000_0000;
    end
    rq.delete();
  endtask

  task automatic model_cycle(input int u, input int lat, input logic [N-1:0] rdy,
                             input logic bsy, input logic [N-1:0] rv,
                             input logic [31:0] rd, input logic [15:0] ma);
    logic [N-1:0] erdy;
    logic [N-1:0] erv;
    logic [15:0]  a;
    int w;
    int hit;
    string pfx;
    pfx  = (u == 0) ? "L1" : "L3";
    erdy = '0;
    erv  = '0;
    w    = -1;
    hit  = -1;
    if (k >= next_win[u]) begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (rr_m[u] + j) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
    end
    if (w >= 0) erdy[w] = 1'b1;
    for (int i = 0; i < rq.size(); i++) begin
      if (hit < 0 && rq[i].u == u && rq[i].cyc == k) hit = i;
    end
    if (hit >= 0) begin
      erv[rq[hit].idx] = 1'b1;
      edata[u] = rq[hit].d;
      rq.delete(hit);
    end
    check({pfx, "_req_ready"}, 32'(rdy), 32'(erdy));
    check({pfx, "_busy"}, 32'(bsy), 32'(k <= busy_end[u]));
    check({pfx, "_rsp_valid"}, 32'(rv), 32'(erv));
    check({pfx, "_rsp_data"}, rd, edata[u]);
    check({pfx, "_mem_addr"}, 32'(ma), 32'(eaddr[u]));
    if (w >= 0) begin
      a = req_addr[16*w +: 16];
      rr_m[u]     = w;
      next_win[u] = k + lat;
      busy_end[u] = k + lat;
      eaddr[u]    = a;
      rq.push_back('{u, k + lat + 1, w, memf(a)});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_L1_busy"}, 32'(bsy1), 32'd0);
    check({tag, "_L3_busy"}, 32'(bsy3), 32'd0);
    check({tag, "_L1_rsp_valid"}, 32'(rv1), 32'd0);
    check({tag, "_L3_rsp_valid"}, 32'(rv3), 32'd0);
    check({tag, "_L1_rsp_data"}, rd1, 32'd0);
    check({tag, "_L3_rsp_data"}, rd3, 32'd0);
    check({tag, "_L1_mem_addr"}, 32'(ma1), 32'd0);
    check({tag, "_L3_mem_addr"}, 32'(ma3), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    #1;
    check_reset_outputs("midread_rst");
    model_reset();
    @(posedge clk);
    #1;
    check({"midread_rst_L1_rsp_hold"}, 32'(rv1), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (cyc == 41) begin
        do_reset();
      end else begin
        if (cyc == 0) begin
          req_valid = 4'b0001;
          req_addr  = '0;
          req_addr[15:0] = 16'h0010;
        end else if (cyc < 6) begin
          req_valid = 4'b0000;
        end else if (cyc < 30) begin
          req_valid = 4'b1111;
          for (int i = 0; i < N; i++) req_addr[16*i +: 16] = 16'(16'h0100 + i);
        end else if (cyc < 40) begin
          req_valid = 4'b1010;
        end else if (cyc == 40) begin
          req_valid = 4'b0001;
        end else if (cyc == 42) begin
          req_valid = 4'b0011;
        end else begin
          if ($urandom_range(0, 3) != 0) req_valid = 4'($urandom_range(0, 15));
          for (int i = 0; i < N; i++) req_addr[16*i +: 16] = 16'($urandom);
        end
        #1;
        model_cycle(0, 1, rdy1, bsy1, rv1, rd1, ma1);
        model_cycle(1, 3, rdy3, bsy3, rv3, rd3, ma3);
        k++;
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
